timer_compare_unit: RTL and testbench

- Consumes the prescaled `tick` strobe from the clock divisor and runs a period counter with auto-reload (periodic mode) or single-shot operation.
- Has N_CH compare channels. Each channel produces a PWM level, a match pulse and a sticky flag.
- An overflow flag and a combined interrupt output feed the CPU-side register block.

---
 rtl/timer_compare_unit.sv | 114 +++++++++++
 tb/tb_timer_compare_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_compare_unit.sv
// rtl/timer_compare_unit.sv - period counter with shadowed compare channels, PWM, pulses and sticky flags
module timer_compare_unit #(
    parameter int TIMER_BITS = 32,
    parameter int N_CH       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       oneshot,
    input  logic [TIMER_BITS-1:0]      period_in,
    input  logic [N_CH*TIMER_BITS-1:0] cmp_in,
    input  logic [N_CH:0]              irq_en,
    input  logic [N_CH:0]              flag_clr,
    output logic [TIMER_BITS-1:0]      count,
    output logic                       running,
    output logic [N_CH-1:0]            pwm,
    output logic                       ovf_pulse,
    output logic [N_CH-1:0]            cmp_pulse,
    output logic [N_CH:0]              flags,
    output logic                       irq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [TIMER_BITS-1:0]       count_q, count_d;
    logic [TIMER_BITS-1:0]       period_q, period_d;
    logic [N_CH*TIMER_BITS-1:0]  cmp_q, cmp_d;
    logic                        oneshot_q, oneshot_d;
    logic [N_CH:0]               flags_q, flags_d;
    logic                        ovf_q, ovf_d;
    logic [N_CH-1:0]             cmp_pulse_q, cmp_pulse_d;
    logic [N_CH:0]               flag_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            period_q    <= '0;
            cmp_q       <= '0;
            oneshot_q   <= 1'b0;
            flags_q     <= '0;
            ovf_q       <= 1'b0;
            cmp_pulse_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            period_q    <= period_d;
            cmp_q       <= cmp_d;
            oneshot_q   <= oneshot_d;
            flags_q     <= flags_d;
            ovf_q       <= ovf_d;
            cmp_pulse_q <= cmp_pulse_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        period_d    = period_q;
        cmp_d       = cmp_q;
        oneshot_d   = oneshot_q;
        ovf_d       = 1'b0;
        cmp_pulse_d = '0;
        flag_set    = '0;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d   = RUN;
            count_d   = '0;
            period_d  = period_in;
            cmp_d     = cmp_in;
            oneshot_d = oneshot;
        end else if (tick && state_q == RUN) begin
            // Matches use the shadow values in force before any terminal-count reload.
            for (int i = 0; i < N_CH; i++) begin
                if (count_q == cmp_q[i*TIMER_BITS +: TIMER_BITS]) begin
                    cmp_pulse_d[i] = 1'b1;
                    flag_set[i+1]  = 1'b1;
                end
            end
            if (count_q == period_q) begin
                count_d     = '0;
                ovf_d       = 1'b1;
                flag_set[0] = 1'b1;
                period_d    = period_in;
                cmp_d       = cmp_in;
                if (oneshot_q) state_d = DONE;
            end else begin
                count_d = count_q + 1'b1;
            end
        end

        flags_d = (flags_q & ~flag_clr) | flag_set;
    end

    always_comb begin
        pwm = '0;
        for (int i = 0; i < N_CH; i++) begin
            pwm[i] = (state_q == RUN) && (count_q < cmp_q[i*TIMER_BITS +: TIMER_BITS]);
        end
    end

    assign count     = count_q;
    assign running   = (state_q == RUN);
    assign ovf_pulse = ovf_q;
    assign cmp_pulse = cmp_pulse_q;
    assign flags     = flags_q;
    assign irq       = |(flags_q & irq_en);

endmodule

// File: tb/tb_timer_compare_unit.sv
// tb/tb_timer_compare_unit.sv - randomized and directed bench for timer_compare_unit against a behavioural model
module tb_timer_compare_unit;

    localparam int TB = 8;
    localparam int NC = 2;

    logic            clk = 1'b0;
    logic            rst, tick, start, stop, oneshot;
    logic [TB-1:0]   period_in;
    logic [NC*TB-1:0] cmp_in;
    logic [NC:0]     irq_en, flag_clr;
    logic [TB-1:0]   count;
    logic            running;
    logic [NC-1:0]   pwm;
    logic            ovf_pulse;
    logic [NC-1:0]   cmp_pulse;
    logic [NC:0]     flags;
    logic            irq;

    int n_chk = 0;
    int n_pass = 0;

    // Behavioural model: plain counters and mode variables.
    int        m_mode;   // 0 stopped, 1 counting, 2 finished
    int        m_count, m_period;
    int        m_cmp [NC];
    bit        m_os;
    bit [NC:0] m_flags;
    bit        m_ovf;
    bit [NC-1:0] m_cp;

    timer_compare_unit #(.TIMER_BITS(TB), .N_CH(NC)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
        .oneshot(oneshot), .period_in(period_in), .cmp_in(cmp_in),
        .irq_en(irq_en), .flag_clr(flag_clr), .count(count), .running(running),
        .pwm(pwm), .ovf_pulse(ovf_pulse), .cmp_pulse(cmp_pulse), .flags(flags), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic model_clk();
        bit [NC:0]   ev = '0;
        bit [NC-1:0] cp = '0;
        bit          ov = 1'b0;
        if (rst) begin
            m_mode = 0; m_count = 0; m_period = 0; m_os = 0;
            for (int i = 0; i < NC; i++) m_cmp[i] = 0;
            m_flags = '0; m_ovf = 0; m_cp = '0;
            return;
        end
        if (stop) m_mode = 0;
        else if (start) begin
            m_mode = 1; m_count = 0; m_period = period_in; m_os = oneshot;
            for (int i = 0; i < NC; i++) m_cmp[i] = cmp_in[i*TB +: TB];
        end else if (tick && m_mode == 1) begin
            for (int i = 0; i < NC; i++)
                if (m_count == m_cmp[i]) begin cp[i] = 1; ev[i+1] = 1; end
            if (m_count == m_period) begin
                ov = 1; ev[0] = 1; m_count = 0; m_period = period_in;
                for (int i = 0; i < NC; i++) m_cmp[i] = cmp_in[i*TB +: TB];
                if (m_os) m_mode = 2;
            end else m_count = m_count + 1;
        end
        m_flags = (m_flags & ~flag_clr) | ev;
        m_ovf = ov; m_cp = cp;
    endtask

    function automatic logic [17:0] exp_vec();
        logic [NC-1:0] p;
        for (int i = 0; i < NC; i++) p[i] = (m_mode == 1) && (m_count < m_cmp[i]);
        return {m_count[TB-1:0], m_mode == 1, p, m_ovf, m_cp, m_flags, |(m_flags & irq_en)};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {count, running, pwm, ovf_pulse, cmp_pulse, flags, irq};
    endfunction

    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; tick = 0; start = 0; stop = 0; flag_clr = '0;
    endtask

    task automatic test_reset();
        rst = 1; tick = 0; start = 0; stop = 0; oneshot = 0; period_in = '0;
        cmp_in = '0; irq_en = '1; flag_clr = '0;
        step(); step();
        n_chk++; if (dut_vec() !== 18'd0) $display("FAIL reset_outputs got=%h exp=0", dut_vec()); else n_pass++;
        n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL reset_model got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_periodic();
        int ovf_seen = 0;
        idle_inputs(); irq_en = '0; oneshot = 0; period_in = 3; cmp_in = {8'd10, 8'd2};
        start = 1; step(); start = 0;
        n_chk++; if (count !== 0 || running !== 1) $display("FAIL periodic_start count=%0d run=%b exp 0/1", count, running); else n_pass++;
        tick = 1;
        for (int n = 1; n <= 12; n++) begin
            step();
            n_chk++;
            if (count !== TB'(n % 4) || pwm[0] !== ((n % 4) < 2) || ovf_pulse !== ((n % 4) == 0)
                || cmp_pulse[0] !== ((n % 4) == 3) || pwm[1] !== 1'b1 || cmp_pulse[1] !== 1'b0)
                $display("FAIL periodic_seq n=%0d got cnt=%0d pwm=%b ovf=%b cp=%b", n, count, pwm, ovf_pulse, cmp_pulse);
            else n_pass++;
            if (ovf_pulse) ovf_seen++;
        end
        n_chk++; if (ovf_seen !== 3) $display("FAIL periodic_ovf_count got=%0d exp=3", ovf_seen); else n_pass++;
        n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL periodic_model got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_oneshot();
        int ovf_seen = 0;
        idle_inputs(); oneshot = 1; period_in = 2; cmp_in = {8'd1, 8'd1};
        start = 1; step(); start = 0;
        for (int c = 1; c <= 18; c++) begin
            tick = (c % 3 == 0);
            step();
            if (ovf_pulse) ovf_seen++;
        end
        tick = 0;
        n_chk++; if (ovf_seen !== 1) $display("FAIL oneshot_ovf got=%0d exp=1", ovf_seen); else n_pass++;
        n_chk++; if (running !== 0 || count !== 0 || pwm !== 0) $display("FAIL oneshot_done run=%b cnt=%0d pwm=%b exp 0/0/0", running, count, pwm); else n_pass++;
        start = 1; step(); start = 0; tick = 1; step(); tick = 0;
        n_chk++; if (running !== 1 || count !== 1) $display("FAIL oneshot_relaunch run=%b cnt=%0d exp 1/1", running, count); else n_pass++;
        n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL oneshot_model got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_shadow();
        int max_before = 0, max_after = 0;
        bit wrapped = 0;
        idle_inputs(); oneshot = 0; period_in = 3; cmp_in = {8'd10, 8'd2};
        start = 1; step(); start = 0; tick = 1;
        for (int c = 0; c < 12; c++) begin
            if (count == 1 && !wrapped) begin period_in = 5; cmp_in = {8'd10, 8'd4}; end
            step();
            if (ovf_pulse) wrapped = 1;
            if (!wrapped && count > max_before) max_before = count;
            if (wrapped && count > max_after) max_after = count;
            n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL shadow_model c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); else n_pass++;
        end
        n_chk++; if (max_before !== 3 || max_after !== 5) $display("FAIL shadow_period got=%0d/%0d exp=3/5", max_before, max_after); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_flags();
        idle_inputs(); irq_en = 3'b001; period_in = 0; cmp_in = {8'd10, 8'd0};
        rst = 1; step(); rst = 0;
        start = 1; step(); start = 0;
        n_chk++; if (pwm[0] !== 0 || pwm[1] !== 1) $display("FAIL edge_pwm got=%b exp=10", pwm); else n_pass++;
        tick = 1; flag_clr = 3'b111; step(); tick = 0;
        n_chk++; if (flags !== 3'b011 || irq !== 1 || ovf_pulse !== 1) $display("FAIL flag_set_wins flags=%b irq=%b ovf=%b exp 011/1/1", flags, irq, ovf_pulse); else n_pass++;
        flag_clr = 3'b001; step(); flag_clr = 0;
        n_chk++; if (flags !== 3'b010 || irq !== 0) $display("FAIL flag_clear flags=%b irq=%b exp 010/0", flags, irq); else n_pass++;
        tick = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++; if (ovf_pulse !== 1 || count !== 0 || cmp_pulse !== 2'b01) $display("FAIL edge_period0 ovf=%b cnt=%0d cp=%b exp 1/0/01", ovf_pulse, count, cmp_pulse); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_allones();
        int ovf_at = -1;
        idle_inputs(); period_in = 8'hFF; cmp_in = {8'd10, 8'd200}; oneshot = 0;
        start = 1; step(); start = 0; tick = 1;
        for (int n = 1; n <= 260; n++) begin
            step();
            if (ovf_pulse && ovf_at < 0) ovf_at = n;
        end
        n_chk++; if (ovf_at !== 256) $display("FAIL allones_wrap got=%0d exp=256", ovf_at); else n_pass++;
        n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL allones_model got=%h exp=%h", dut_vec(), exp_vec()); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_control();
        idle_inputs(); period_in = 3; cmp_in = {8'd10, 8'd2}; irq_en = '1;
        start = 1; step(); start = 0; tick = 1; step(); step();
        n_chk++; if (count !== 2) $display("FAIL ctrl_precount got=%0d exp=2", count); else n_pass++;
        rst = 1; step(); rst = 0; tick = 0;
        n_chk++; if (dut_vec() !== 18'd0) $display("FAIL ctrl_reset got=%h exp=0", dut_vec()); else n_pass++;
        start = 1; step(); start = 0; tick = 1; step(); step();
        stop = 1; start = 1; step(); stop = 0; start = 0; tick = 0;
        n_chk++; if (running !== 0 || count !== 2 || ovf_pulse !== 0 || cmp_pulse !== 0) $display("FAIL ctrl_stop_start run=%b cnt=%0d exp 0/2", running, count); else n_pass++;
        tick = 1; step(); tick = 0;
        n_chk++; if (count !== 2) $display("FAIL ctrl_tick_idle got=%0d exp=2", count); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            stop     = ($urandom_range(0, 49) == 0);
            start    = ($urandom_range(0, 24) == 0);
            tick     = $urandom_range(0, 1);
            oneshot  = ($urandom_range(0, 3) == 0);
            period_in = TB'($urandom_range(0, 7));
            cmp_in   = {TB'($urandom_range(0, 9)), TB'($urandom_range(0, 9))};
            irq_en   = 3'($urandom);
            flag_clr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            step();
            n_chk++; if (dut_vec() !== exp_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec()); else n_pass++;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_shadow();
        test_flags();
        test_allones();
        test_control();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
